// File: rtl/triangle_scanner.sv
// rtl/triangle_scanner.sv - bounding-box pixel walker feeding the triangle rasterizer
// Optional statistics counters are built when TRIANGLE_SCANNER_STATS_EN is defined.
module triangle_scanner #(
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tri_valid,
   output logic               tri_ready,
   input  logic signed [10:0] V1_x_in,
   input  logic signed [10:0] V1_y_in,
   input  logic signed [10:0] V2_x_in,
   input  logic signed [10:0] V2_y_in,
   input  logic signed [10:0] V3_x_in,
   input  logic signed [10:0] V3_y_in,
   output logic [10:0]        pixel_x,
   output logic [10:0]        pixel_y,
   output logic signed [10:0] V1_x,
   output logic signed [10:0] V1_y,
   output logic signed [10:0] V2_x,
   output logic signed [10:0] V2_y,
   output logic signed [10:0] V3_x,
   output logic signed [10:0] V3_y,
   output logic               outValid,
   input  logic               outReady,
   output logic               last,
`ifdef TRIANGLE_SCANNER_STATS_EN
   output logic [31:0]        stat_tris,
   output logic [31:0]        stat_culled,
   output logic [31:0]        stat_pixels,
`endif
   output logic               busy
);

   localparam logic signed [11:0] X_LIM = 12'(SCREEN_W - 1);
   localparam logic signed [11:0] Y_LIM = 12'(SCREEN_H - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BBOX = 2'd1,
      S_SCAN = 2'd2
   } state_e;

   state_e             state_q;
   logic               tri_ready_q;
   logic               out_valid_q;
   logic               last_q;
   logic [10:0]        px_q, py_q;
   logic [10:0]        xmin_q, xmax_q, ymax_q;
   logic signed [10:0] v1x_q, v1y_q, v2x_q, v2y_q, v3x_q, v3y_q;
`ifdef TRIANGLE_SCANNER_STATS_EN
   logic [31:0]        stat_tris_q, stat_culled_q, stat_pixels_q;
`endif

   // Bounding box of the latched vertices, widened to 12 bits so clamping compares are safe
   logic signed [11:0] bx_lo_d, bx_hi_d, by_lo_d, by_hi_d;
   logic               bb_empty_d;

   function automatic logic signed [11:0] smin(input logic signed [11:0] a,
                                                input logic signed [11:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic signed [11:0] smax(input logic signed [11:0] a,
                                                input logic signed [11:0] b);
      return (a > b) ? a : b;
   endfunction

   // Min/max of the three vertices, then clip to the visible screen
   always_comb begin
      logic signed [11:0] ax, bx, cx, ay, by, cy;
      ax = {v1x_q[10], v1x_q};
      bx = {v2x_q[10], v2x_q};
      cx = {v3x_q[10], v3x_q};
      ay = {v1y_q[10], v1y_q};
      by = {v2y_q[10], v2y_q};
      cy = {v3y_q[10], v3y_q};
      bx_lo_d    = smax(smin(smin(ax, bx), cx), 12'sd0);
      bx_hi_d    = smin(smax(smax(ax, bx), cx), X_LIM);
      by_lo_d    = smax(smin(smin(ay, by), cy), 12'sd0);
      by_hi_d    = smin(smax(smax(ay, by), cy), Y_LIM);
      bb_empty_d = (bx_lo_d > bx_hi_d) || (by_lo_d > by_hi_d);
   end

   // Control FSM: accept, compute box (1 cycle), then walk the box in raster order
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         tri_ready_q <= 1'b1;
         out_valid_q <= 1'b0;
         last_q      <= 1'b0;
         px_q        <= '0;
         py_q        <= '0;
         xmin_q      <= '0;
         xmax_q      <= '0;
         ymax_q      <= '0;
         v1x_q       <= '0;
         v1y_q       <= '0;
         v2x_q       <= '0;
         v2y_q       <= '0;
         v3x_q       <= '0;
         v3y_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (tri_valid && tri_ready_q) begin
                  v1x_q       <= V1_x_in;
                  v1y_q       <= V1_y_in;
                  v2x_q       <= V2_x_in;
                  v2y_q       <= V2_y_in;
                  v3x_q       <= V3_x_in;
                  v3y_q       <= V3_y_in;
                  tri_ready_q <= 1'b0;
                  state_q     <= S_BBOX;
               end
            end
            S_BBOX: begin
               if (bb_empty_d) begin
                  tri_ready_q <= 1'b1;
                  state_q     <= S_IDLE;
               end else begin
                  // Non-empty box lies within the screen, so the low 11 bits hold it exactly
                  xmin_q  <= bx_lo_d[10:0];
                  xmax_q  <= bx_hi_d[10:0];
                  ymax_q  <= by_hi_d[10:0];
                  px_q    <= bx_lo_d[10:0];
                  py_q    <= by_lo_d[10:0];
                  state_q <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (!out_valid_q) begin
                  // First scan cycle: present the opening beat
                  out_valid_q <= 1'b1;
                  last_q      <= (px_q == xmax_q) && (py_q == ymax_q);
               end else if (outReady) begin
                  if (px_q != xmax_q) begin
                     px_q   <= px_q + 11'd1;
                     last_q <= ((px_q + 11'd1) == xmax_q) && (py_q == ymax_q);
                  end else if (py_q != ymax_q) begin
                     px_q   <= xmin_q;
                     py_q   <= py_q + 11'd1;
                     last_q <= (xmin_q == xmax_q) && ((py_q + 11'd1) == ymax_q);
                  end else begin
                     out_valid_q <= 1'b0;
                     last_q      <= 1'b0;
                     tri_ready_q <= 1'b1;
                     state_q     <= S_IDLE;
                  end
               end
            end
            default: begin
               state_q     <= S_IDLE;
               tri_ready_q <= 1'b1;
               out_valid_q <= 1'b0;
               last_q      <= 1'b0;
            end
         endcase
      end
   end

`ifdef TRIANGLE_SCANNER_STATS_EN
   // Free-running event counters; they wrap naturally at 2^32
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_tris_q   <= '0;
         stat_culled_q <= '0;
         stat_pixels_q <= '0;
      end else begin
         if (state_q == S_IDLE && tri_valid && tri_ready_q)
            stat_tris_q <= stat_tris_q + 32'd1;
         if (state_q == S_BBOX && bb_empty_d)
            stat_culled_q <= stat_culled_q + 32'd1;
         if (state_q == S_SCAN && out_valid_q && outReady)
            stat_pixels_q <= stat_pixels_q + 32'd1;
      end
   end

   assign stat_tris   = stat_tris_q;
   assign stat_culled = stat_culled_q;
   assign stat_pixels = stat_pixels_q;
`endif

   assign tri_ready = tri_ready_q;
   assign outValid  = out_valid_q;
   assign last      = last_q;
   assign pixel_x   = px_q;
   assign pixel_y   = py_q;
   assign V1_x      = v1x_q;
   assign V1_y      = v1y_q;
   assign V2_x      = v2x_q;
   assign V2_y      = v2y_q;
   assign V3_x      = v3x_q;
   assign V3_y      = v3y_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_triangle_scanner.sv
// tb/tb_triangle_scanner.sv - scoreboard bench for triangle_scanner
module tb_triangle_scanner;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               tri_valid = 1'b0;
   logic               tri_ready;
   logic signed [10:0] V1_x_in = '0, V1_y_in = '0, V2_x_in = '0, V2_y_in = '0, V3_x_in = '0, V3_y_in = '0;
   logic [10:0]        pixel_x, pixel_y;
   logic signed [10:0] V1_x, V1_y, V2_x, V2_y, V3_x, V3_y;
   logic               outValid;
   logic               outReady = 1'b1;
   logic               last;
   logic               busy;
`ifdef TRIANGLE_SCANNER_STATS_EN
   logic [31:0]        stat_tris, stat_culled, stat_pixels;
`endif

   triangle_scanner #(.SCREEN_W(640), .SCREEN_H(480)) dut (
      .clk(clk), .rst_n(rst_n), .tri_valid(tri_valid), .tri_ready(tri_ready),
      .V1_x_in(V1_x_in), .V1_y_in(V1_y_in), .V2_x_in(V2_x_in),
      .V2_y_in(V2_y_in), .V3_x_in(V3_x_in), .V3_y_in(V3_y_in),
      .pixel_x(pixel_x), .pixel_y(pixel_y),
      .V1_x(V1_x), .V1_y(V1_y), .V2_x(V2_x), .V2_y(V2_y), .V3_x(V3_x), .V3_y(V3_y),
      .outValid(outValid), .outReady(outReady), .last(last),
`ifdef TRIANGLE_SCANNER_STATS_EN
      .stat_tris(stat_tris), .stat_culled(stat_culled), .stat_pixels(stat_pixels),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [10:0] x;
      logic [10:0] y;
      logic        lst;
      logic [65:0] v;
   } beat_t;

   beat_t       sb[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          n_pop = 0;
   logic        mon_en = 1'b0;
   int          rdy_mode = 0;
   logic        stall_pend = 1'b0;
   logic [98:0] held;

   task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected beats come from an independent loop over the clipped box
   task automatic send_tri(input int x1, input int y1, input int x2, input int y2,
                           input int x3, input int y3);
      int xl, xh, yl, yh;
      beat_t b;
      logic [65:0] vv;
      xl = (x1 < x2) ? x1 : x2; xl = (x3 < xl) ? x3 : xl;
      xh = (x1 > x2) ? x1 : x2; xh = (x3 > xh) ? x3 : xh;
      yl = (y1 < y2) ? y1 : y2; yl = (y3 < yl) ? y3 : yl;
      yh = (y1 > y2) ? y1 : y2; yh = (y3 > yh) ? y3 : yh;
      if (xl < 0) xl = 0;
      if (yl < 0) yl = 0;
      if (xh > 639) xh = 639;
      if (yh > 479) yh = 479;
      vv = {11'(x1), 11'(y1), 11'(x2), 11'(y2), 11'(x3), 11'(y3)};
      for (int y = yl; y <= yh; y++)
         for (int x = xl; x <= xh; x++) begin
            b.x = 11'(x); b.y = 11'(y); b.v = vv;
            b.lst = (x == xh) && (y == yh);
            sb.push_back(b);
         end
      @(posedge clk); #1;
      tri_valid = 1'b1;
      V1_x_in = 11'(x1); V1_y_in = 11'(y1);
      V2_x_in = 11'(x2); V2_y_in = 11'(y2);
      V3_x_in = 11'(x3); V3_y_in = 11'(y3);
      @(posedge clk); #1;
      tri_valid = 1'b0;
   endtask

   task automatic wait_done();
      int i;
      for (i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && tri_ready) break;
      end
      check("done_in_time", (i < 3000), 1);
   endtask

   // outReady pattern: steady high, or 1,0,0 repeating
   initial begin
      int ph;
      ph = 0;
      forever begin
         @(posedge clk); #1;
         if (rdy_mode == 0) outReady = 1'b1;
         else begin
            outReady = (ph == 0);
            ph = (ph + 1) % 3;
         end
      end
   end

   // Output monitor: stability during stalls and scoreboard compare on each transfer
   always @(negedge clk) begin
      if (mon_en && outValid) begin
         if (stall_pend)
            check("stall_hold", {pixel_x, pixel_y, last, V1_x, V1_y, V2_x, V2_y, V3_x, V3_y} == held, 1);
         if (outReady) begin
            stall_pend = 1'b0;
            if (sb.size() == 0) check("unexp_beat", outValid, 0);
            else begin
               beat_t e;
               e = sb.pop_front();
               check("pix_x", pixel_x, e.x);
               check("pix_y", pixel_y, e.y);
               check("last", last, e.lst);
               check("verts", {V1_x, V1_y, V2_x, V2_y, V3_x, V3_y}, e.v);
               n_pop++;
            end
         end else begin
            stall_pend = 1'b1;
            held = {pixel_x, pixel_y, last, V1_x, V1_y, V2_x, V2_y, V3_x, V3_y};
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_tri_ready", tri_ready, 1);
      check("rst_outValid", outValid, 0);
      check("rst_last", last, 0);
      check("rst_busy", busy, 0);
      check("rst_pixel", {pixel_x, pixel_y}, 0);
      check("rst_verts", {V1_x, V1_y, V2_x, V2_y, V3_x, V3_y}, 0);
      rst_n = 1'b1;
      mon_en = 1'b1;

      // Basic 3x3 box with latency checks and ignored tri_valid while busy
      send_tri(1, 1, 3, 1, 1, 3);
      @(negedge clk);
      check("lat_n0_valid", outValid, 0);
      check("lat_n0_ready", tri_ready, 0);
      check("lat_n0_busy", busy, 1);
      @(negedge clk);
      check("lat_n1_valid", outValid, 0);
      @(negedge clk);
      check("lat_n2_valid", outValid, 1);
      tri_valid = 1'b1;
      V1_x_in = 11'sd100; V1_y_in = 11'sd100; V2_x_in = 11'sd200;
      repeat (3) @(negedge clk);
      tri_valid = 1'b0;
      wait_done();

      // Fully off-screen triangle is culled
      send_tri(-10, -10, -5, -2, -1, -8);
      @(negedge clk);
      check("cull_ready_lo", tri_ready, 0);
      @(negedge clk);
      check("cull_ready_hi", tri_ready, 1);
      check("cull_no_valid", outValid, 0);
      check("cull_idle", busy, 0);
`ifdef TRIANGLE_SCANNER_STATS_EN
      check("stat_culled", stat_culled, 1);
      check("stat_tris", stat_tris, 2);
      check("stat_pixels", stat_pixels, 9);
`endif
      repeat (3) @(negedge clk);

      // Clipped at the bottom-left corner: 6 x 10 beats
      send_tri(-2, 470, 5, 490, 0, 479);
      wait_done();

      // Degenerate point triangle
      send_tri(7, 7, 7, 7, 7, 7);
      begin
         int i;
         for (i = 0; i < 20 && !outValid; i++) @(negedge clk);
         check("pt_valid_seen", outValid, 1);
         check("pt_last", last, 1);
         @(negedge clk);
         check("pt_ready_next", tri_ready, 1);
         check("pt_valid_drop", outValid, 0);
      end

      // Backpressure with ready toggling 1,0,0
      rdy_mode = 1;
      send_tri(1, 1, 3, 1, 1, 3);
      wait_done();
      rdy_mode = 0;
      repeat (2) @(negedge clk);

      // Reset in the middle of the scan, during beat 4
      n_pop = 0;
      send_tri(1, 1, 3, 1, 1, 3);
      begin
         int i;
         for (i = 0; i < 100 && n_pop < 3; i++) @(posedge clk);
         check("mid_reach_beat4", n_pop, 3);
      end
      #2;
      mon_en = 1'b0;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", outValid, 0);
      check("mid_rst_ready", tri_ready, 1);
      check("mid_rst_pixel", {pixel_x, pixel_y}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      stall_pend = 1'b0;
      mon_en = 1'b1;
      send_tri(4, 2, 6, 2, 5, 3);
      wait_done();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/triangle_scanner.md
Name: triangle_scanner

Overview:
Upstream feeder for the per-pixel triangle rasterizer. Accepts one triangle (three signed 11-bit vertices) per handshake. Computes its screen-clipped bounding box and walks it in raster order, emitting one pixel coordinate per beat. The triangle's vertices are held stable alongside each beat, so the downstream edge-function stage can evaluate coverage.

Parameters:
SCREEN_W, 640, visible width in pixels; clip range x = 0..SCREEN_W-1
SCREEN_H, 480, visible height in pixels; clip range y = 0..SCREEN_H-1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
tri_valid  input  1  triangle available on V*_in
tri_ready  output  1  scanner can accept a triangle
V1_x_in, V1_y_in, V2_x_in, V2_y_in, V3_x_in, V3_y_in  input  11 each (signed)  triangle vertices
pixel_x  output  11  current pixel column
pixel_y  output  11  current pixel row
V1_x, V1_y, V2_x, V2_y, V3_x, V3_y  output  11 each (signed)  latched vertices, constant for the whole triangle
outValid  output  1  pixel beat valid
outReady  input  1  downstream accepts the beat
last  output  1  current beat is the final pixel of the triangle
busy  output  1  high in BBOX or SCAN

Behaviour:
- Reset: state=IDLE. tri_ready=1, outValid=0, last=0, busy=0. pixel_x, pixel_y and all V* outputs = 0.
- Reset asserted mid-operation aborts the triangle immediately. No further beats are emitted.
- IDLE:
  - tri_ready=1.
  - On tri_valid & tri_ready, latch all six vertices and go to BBOX.
- BBOX (exactly 1 cycle, tri_ready=0, outValid=0):
  - xmin/xmax/ymin/ymax = signed min/max of the three vertices, computed at 12-bit signed width.
  - Clamp: xmin = max(xmin, 0); xmax = min(xmax, SCREEN_W-1); same for y with SCREEN_H-1.
  - Empty if xmin > xmax or ymin > ymax after clamping (triangle fully off-screen): return to IDLE with no beats (culled).
  - Otherwise load pixel_x = xmin, pixel_y = ymin and go to SCAN.
- SCAN:
  - outValid=1.
  - last=1 iff pixel_x==xmax and pixel_y==ymax.
- Handshake:
  - A beat transfers when outValid & outReady.
  - pixel_x, pixel_y, V*, last and outValid hold stable while outReady=0.
  - outValid never drops without a transfer.
- Advance on transfer:
  - If pixel_x != xmax: pixel_x += 1.
  - Else if pixel_y != ymax: pixel_x = xmin, pixel_y += 1.
  - Else (last beat): outValid=0 and go to IDLE.
- Timing:
  - Triangle accepted at edge N; first outValid high after edge N+2.
  - Throughput: 1 pixel/clk with outReady held high.
  - tri_ready rises on the cycle after the last transfer; no overlap between triangles.
- Beat count = (xmax-xmin+1)*(ymax-ymin+1). A degenerate point triangle yields exactly 1 beat with last=1.
- tri_valid while not in IDLE is ignored: tri_ready=0 and nothing is latched.

Optional Feature:
- Macro: TRIANGLE_SCANNER_STATS_EN.
- When defined, adds three outputs:
  - stat_tris (32): triangles accepted.
  - stat_culled (32): triangles culled in BBOX.
  - stat_pixels (32): beats transferred.
- All three counters reset to 0 on rst_n and wrap modulo 2^32.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Vertices (1,1),(3,1),(1,3), outReady=1 -> 9 beats (1,1),(2,1),(3,1),(1,2)...(3,3). last only on (3,3). First outValid 2 cycles after accept.
- Vertices (-10,-10),(-5,-2),(-1,-8) -> no outValid. tri_ready=0 for exactly 1 cycle (BBOX), then back to 1. stat_culled=1 if STATS_EN.
- Vertices (-2,470),(5,490),(0,479) -> clipped box x 0..5, y 470..479. 60 beats, first (0,470), last (5,479).
- Point (7,7) x3 -> single beat (7,7) with last=1, then tri_ready=1 next cycle.
- Triangle (1,1),(3,1),(1,3) with outReady toggling 1,0,0,1,... -> outputs stable during stalls. Same 9-beat sequence, no duplicates or drops.
- Assert rst_n low during beat 4 of a 9-beat scan -> outValid=0, tri_ready=1, pixel_x=pixel_y=0 immediately. New triangle then scans normally from its xmin/ymin.
